pyr_clk_en_gen: RTL

Parametrised multi-channel clock-enable generator for the pyramidal LK datapath. It replaces ripple-clocked toggle dividers with single-domain enables: every output is a flop clocked by `clk`. Each channel produces a one-cycle strobe `ce` and a registered square wave `clk_out`, at a runtime-programmable divide ratio. Pyramid level k uses channel k, and its reset ratio is 2^(k+1).

---
 rtl/pyr_clk_pkg.sv | 24 ++
 rtl/pyr_clk_en_ch.sv | 119 +++++++++++
 rtl/pyr_clk_en_gen.sv | 37 +++
 3 files changed

// File: rtl/pyr_clk_pkg.sv
// Shared types and helpers for the pyramid clock-enable generator.
// Holds the channel FSM encoding and the per-level reset ratio function.
package pyr_clk_pkg;

  localparam int MAX_CH = 8;

  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } ch_state_t;

  // Level k divides by 2^(k+1), saturated to the widest counter value.
  function automatic longint unsigned reset_div(
    input int k,
    input int cnt_w
  );
    longint unsigned v;
    longint unsigned m;
    v = 64'd2 << k;
    m = (64'd1 << cnt_w) - 64'd1;
    return (v < m) ? v : m;
  endfunction

endpackage

// File: rtl/pyr_clk_en_ch.sv
// One divider channel: counter, divisor/shadow, RUN/PEND FSM, output flops.
// PYR_SYNC_LOAD_EN: defer loads to the terminal count (else apply next edge).
module pyr_clk_en_ch
  import pyr_clk_pkg::*;
#(
  parameter int CNT_W  = 8,
  parameter int CH_IDX = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             sync_clr_i,
  input  logic             div_load_i,
  input  logic [CNT_W-1:0] div_val_i,
  output logic             ce_o,
  output logic             clk_out_o,
  output logic             busy_o
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] RST_DIV =
    CNT_W'(reset_div(CH_IDX, CNT_W));

  ch_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] sh_q, sh_d;
  logic             ce_q, ce_d;
  logic             co_q, co_d;

  logic [CNT_W-1:0] div_eff;
  logic [CNT_W-1:0] term_val;
  logic [CNT_W-1:0] half;
  logic             term;

  // N=0 behaves as N=1; D-1 stays in CNT_W bits so all-ones is legal.
  assign div_eff  = (div_q == '0) ? ONE : div_q;
  assign term_val = div_eff - ONE;
  assign half     = div_eff >> 1;
  assign term     = (cnt_q == term_val);

`ifndef PYR_SYNC_LOAD_EN
  logic sh_one;
  assign sh_one = (sh_q <= ONE);
`endif

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
      div_q   <= RST_DIV;
      sh_q    <= '0;
      ce_q    <= 1'b0;
      co_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      sh_q    <= sh_d;
      ce_q    <= ce_d;
      co_q    <= co_d;
    end
  end

  // Counting, load FSM and output next-state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    sh_d    = sh_q;
    ce_d    = 1'b0;
    co_d    = co_q;
    if (sync_clr_i) begin
      cnt_d   = '0;
      co_d    = 1'b0;
      state_d = RUN;
      if (state_q == PEND) begin
        div_d = sh_q;
      end
    end else begin
      if (en_i) begin
        ce_d  = term;
        co_d  = (cnt_q < half);
        cnt_d = term ? '0 : cnt_q + ONE;
      end
      if (en_i && term && div_load_i) begin
        div_d   = div_val_i;
        state_d = RUN;
      end else if (div_load_i) begin
        sh_d    = div_val_i;
        state_d = PEND;
      end else if (state_q == PEND) begin
`ifdef PYR_SYNC_LOAD_EN
        if (en_i && term) begin
          div_d   = sh_q;
          state_d = RUN;
        end
`else
        div_d   = sh_q;
        state_d = RUN;
        if (en_i) begin
          cnt_d = sh_one ? '0 : ONE;
          ce_d  = sh_one;
          co_d  = !sh_one;
        end else begin
          cnt_d = '0;
          co_d  = 1'b0;
        end
`endif
      end
    end
  end

  assign ce_o      = ce_q;
  assign clk_out_o = co_q;
  assign busy_o    = (state_q == PEND);

endmodule

// File: rtl/pyr_clk_en_gen.sv
// Multi-channel single-domain clock-enable generator for the LK pyramid.
// Load timing selected by PYR_SYNC_LOAD_EN (see pyr_clk_en_ch).
module pyr_clk_en_gen
  import pyr_clk_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    sync_clr,
  input  logic [NUM_CH-1:0]       div_load,
  input  logic [NUM_CH*CNT_W-1:0] div_val,
  output logic [NUM_CH-1:0]       ce,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       busy
);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    pyr_clk_en_ch #(
      .CNT_W  (CNT_W),
      .CH_IDX (k)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .en_i       (en),
      .sync_clr_i (sync_clr),
      .div_load_i (div_load[k]),
      .div_val_i  (div_val[k*CNT_W +: CNT_W]),
      .ce_o       (ce[k]),
      .clk_out_o  (clk_out[k]),
      .busy_o     (busy[k])
    );
  end

endmodule
